// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending (scoreboard) bits, byte-lane writeback,
// optional write-to-read forwarding, and a registered count of pending registers.
module scoreboard_regfile #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG),
  localparam int NB    = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [NB-1:0]   wbe,
  input  logic            iss,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;
  logic [AW:0]     cnt_nxt;
  logic [XLEN-1:0] wr_merged;
  logic            wr_en;
  logic            set_en;
  logic            fwd1;
  logic            fwd2;

  assign wr_en  = we && (wa != '0);
  assign set_en = iss && (iss_rd != '0);
  assign fwd1   = (BYPASS != 0) && wr_en && (ra1 == wa);
  assign fwd2   = (BYPASS != 0) && wr_en && (ra2 == wa);

  // Stored value of the write target with the enabled byte lanes replaced;
  // shared by the array update and the forwarding path.
  always_comb begin
    wr_merged = regs[wa];
    for (int k = 0; k < NB; k++) begin
      if (wbe[k]) begin
        wr_merged[8*k +: 8] = wd[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wa] <= wr_merged;
    end
  end

  // Clear on writeback, then set on issue so a same-cycle set wins; flush beats both.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) begin
      pending_nxt[wa] = 1'b0;
    end
    if (set_en) begin
      pending_nxt[iss_rd] = 1'b1;
    end
    if (flush) begin
      pending_nxt = '0;
    end
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      rd1 = fwd1 ? wr_merged : regs[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      rd2 = fwd2 ? wr_merged : regs[ra2];
    end
  end

  // A forwarded write retires the pending mark early, unless it is re-issued now.
  always_comb begin
    busy1 = 1'b0;
    if (ra1 != '0) begin
      busy1 = fwd1 ? (iss && (iss_rd == ra1)) : pending[ra1];
    end
  end

  always_comb begin
    busy2 = 1'b0;
    if (ra2 != '0) begin
      busy2 = fwd2 ? (iss && (iss_rd == ra2)) : pending[ra2];
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench: directed scenarios plus random traffic against an
// array/bit-vector model; drives a forwarding and a non-forwarding instance.
module tb_scoreboard_regfile;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NB   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   ra1, ra2, wa, iss_rd;
  logic            we, iss, flush;
  logic [XLEN-1:0] wd;
  logic [NB-1:0]   wbe;
  logic [XLEN-1:0] rd1, rd2, rd1_nb, rd2_nb;
  logic            busy1, busy2, busy1_nb, busy2_nb;
  logic [AW:0]     pend_cnt, pend_cnt_nb;

  int total = 0;
  int bad   = 0;

  logic [XLEN-1:0] m_reg [NREG];
  bit              m_pend [NREG];

  always #5 clk = ~clk;

  scoreboard_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss(iss), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt)
  );

  scoreboard_regfile #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .busy1(busy1_nb), .busy2(busy2_nb), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
    .iss(iss), .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt_nb)
  );

  // Reference model: what a read should show given current inputs and stored state.
  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    logic [XLEN-1:0] v;
    if (a == 0) return '0;
    v = m_reg[a];
    if (byp && we && wa != 0 && wa == a) begin
      for (int k = 0; k < NB; k++) if (wbe[k]) v[8*k +: 8] = wd[8*k +: 8];
    end
    return v;
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && wa != 0 && wa == a) return iss && (iss_rd == a);
    return m_pend[a];
  endfunction

  function automatic logic [AW:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) n += m_pend[i];
    return n[AW:0];
  endfunction

  task automatic model_commit();
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
      return;
    end
    if (we && wa != 0) begin
      for (int k = 0; k < NB; k++) if (wbe[k]) m_reg[wa][8*k +: 8] = wd[8*k +: 8];
      m_pend[wa] = 1'b0;
    end
    if (iss && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (flush) for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; we = 0; iss = 0; flush = 0;
    wa = 0; wd = 0; wbe = 0; iss_rd = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; we = 1; wa = 5; wd = $urandom; wbe = 4'hF; iss = 1; iss_rd = 6; flush = 0;
    tick();
    idle();
    for (int a = 0; a < NREG; a++) begin
      ra1 = a[AW-1:0];
      ra2 = 5'(NREG - 1 - a);
      #1;
      total++;
      if (rd1 !== 0 || rd2 !== 0 || busy1 !== 0 || busy2 !== 0 || pend_cnt !== 0) begin
        bad++;
        $display("[TB] FAIL reset_state addr=%0d got rd1=%h rd2=%h b1=%b b2=%b cnt=%0d exp all 0",
                 a, rd1, rd2, busy1, busy2, pend_cnt);
      end
      tick();
    end
  endtask

  task automatic test_basic_write();
    do_reset();
    we = 1; wa = 5; wd = 32'hDEADBEEF; wbe = 4'hF;
    tick();
    idle();
    ra1 = 5; ra2 = 0;
    #1;
    total++;
    if (rd1 !== 32'hDEADBEEF || rd1_nb !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL write_r5 got=%h/%h exp=deadbeef", rd1, rd1_nb);
    end
    total++;
    if (rd2 !== 0 || rd2_nb !== 0) begin
      bad++;
      $display("[TB] FAIL read_r0 got=%h/%h exp=0", rd2, rd2_nb);
    end
    tick();
  endtask

  task automatic test_byte_merge();
    we = 1; wa = 5; wd = 32'h11223344; wbe = 4'b0101;
    tick();
    idle();
    ra1 = 5;
    #1;
    total++;
    if (rd1 !== 32'hDE22BE44 || rd1_nb !== 32'hDE22BE44) begin
      bad++;
      $display("[TB] FAIL byte_merge got=%h/%h exp=de22be44", rd1, rd1_nb);
    end
    we = 1; wa = 5; wd = 32'hFFFFFFFF; wbe = 4'b0000;
    tick();
    idle();
    #1;
    total++;
    if (rd1 !== 32'hDE22BE44) begin
      bad++;
      $display("[TB] FAIL zero_wbe got=%h exp=de22be44", rd1);
    end
    tick();
  endtask

  task automatic test_bypass();
    do_reset();
    iss = 1; iss_rd = 7;
    tick();
    idle();
    we = 1; wa = 7; wd = 32'hA5A5A5A5; wbe = 4'hF; ra1 = 7; ra2 = 7;
    #1;
    total++;
    if (rd1 !== 32'hA5A5A5A5 || rd2 !== 32'hA5A5A5A5 || busy1 !== 0 || busy2 !== 0) begin
      bad++;
      $display("[TB] FAIL bypass_fwd got rd1=%h rd2=%h b1=%b b2=%b exp a5a5a5a5 busy 0",
               rd1, rd2, busy1, busy2);
    end
    total++;
    if (rd1_nb !== 0 || rd2_nb !== 0 || busy1_nb !== 1 || busy2_nb !== 1) begin
      bad++;
      $display("[TB] FAIL nobypass_old got rd1=%h rd2=%h b1=%b b2=%b exp 0 busy 1",
               rd1_nb, rd2_nb, busy1_nb, busy2_nb);
    end
    tick();
    idle();
    #1;
    total++;
    if (rd1_nb !== 32'hA5A5A5A5 || busy1_nb !== 0 || pend_cnt !== 0) begin
      bad++;
      $display("[TB] FAIL nobypass_next got rd1=%h b1=%b cnt=%0d exp a5a5a5a5 0 0",
               rd1_nb, busy1_nb, pend_cnt);
    end
    tick();
  endtask

  task automatic test_pending();
    do_reset();
    iss = 1; iss_rd = 3;
    tick();
    iss_rd = 4;
    tick();
    idle();
    ra1 = 3;
    #1;
    total++;
    if (pend_cnt !== 2 || busy1 !== 1) begin
      bad++;
      $display("[TB] FAIL two_issues got cnt=%0d b1=%b exp 2 1", pend_cnt, busy1);
    end
    we = 1; wa = 3; wd = 32'h0BADF00D; wbe = 4'hF; iss = 1; iss_rd = 3;
    tick();
    idle();
    ra1 = 3;
    #1;
    total++;
    if (pend_cnt !== 2 || busy1 !== 1 || rd1 !== 32'h0BADF00D) begin
      bad++;
      $display("[TB] FAIL set_wins got cnt=%0d b1=%b rd1=%h exp 2 1 0badf00d", pend_cnt, busy1, rd1);
    end
    iss = 1; iss_rd = 4;
    tick();
    idle();
    #1;
    total++;
    if (pend_cnt !== 2) begin
      bad++;
      $display("[TB] FAIL reissue_count got=%0d exp=2", pend_cnt);
    end
    we = 1; wa = 9; wbe = 4'hF; wd = 32'h1;
    tick();
    idle();
    #1;
    total++;
    if (pend_cnt !== 2) begin
      bad++;
      $display("[TB] FAIL clear_idle_count got=%0d exp=2", pend_cnt);
    end
  endtask

  task automatic test_reg0_and_flush();
    do_reset();
    iss = 1; iss_rd = 0; we = 1; wa = 0; wd = 32'hFFFFFFFF; wbe = 4'hF; ra1 = 0; ra2 = 0;
    tick();
    idle();
    #1;
    total++;
    if (pend_cnt !== 0 || rd1 !== 0 || busy1 !== 0) begin
      bad++;
      $display("[TB] FAIL reg0 got cnt=%0d rd1=%h b1=%b exp 0 0 0", pend_cnt, rd1, busy1);
    end
    for (int i = 1; i <= 5; i++) begin
      iss = 1; iss_rd = 5'(i * 3);
      tick();
    end
    idle();
    #1;
    total++;
    if (pend_cnt !== 5) begin
      bad++;
      $display("[TB] FAIL five_pending got=%0d exp=5", pend_cnt);
    end
    flush = 1; iss = 1; iss_rd = 20; we = 1; wa = 6; wd = 32'h600D600D; wbe = 4'hF;
    tick();
    idle();
    ra1 = 20; ra2 = 6;
    #1;
    total++;
    if (pend_cnt !== 0 || busy1 !== 0 || rd2 !== 32'h600D600D) begin
      bad++;
      $display("[TB] FAIL flush got cnt=%0d b1=%b rd2=%h exp 0 0 600d600d", pend_cnt, busy1, rd2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    we = 1; wa = 9; wd = 32'h12345678; wbe = 4'hF; iss = 1; iss_rd = 2;
    tick();
    idle();
    iss = 1; iss_rd = 9;
    tick();
    idle();
    #1;
    total++;
    if (pend_cnt !== 2) begin
      bad++;
      $display("[TB] FAIL pre_reset_count got=%0d exp=2", pend_cnt);
    end
    rst = 1; iss = 1; iss_rd = 6; we = 1; wa = 9; wd = 32'hCAFEBABE; wbe = 4'hF;
    tick();
    idle();
    for (int a = 0; a < NREG; a++) begin
      ra1 = a[AW-1:0]; ra2 = a[AW-1:0];
      #1;
      total++;
      if (rd1 !== 0 || busy1 !== 0 || busy2 !== 0 || pend_cnt !== 0) begin
        bad++;
        $display("[TB] FAIL reset_mid addr=%0d got rd1=%h b1=%b b2=%b cnt=%0d exp all 0",
                 a, rd1, busy1, busy2, pend_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit narrow = $urandom_range(0, 1) == 1;
      rst    = ($urandom_range(0, 63) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      we     = $urandom_range(0, 1) == 1;
      iss    = $urandom_range(0, 1) == 1;
      wa     = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      iss_rd = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra2    = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd     = $urandom;
      wbe    = 4'($urandom);
      #1;
      total++;
      if (rd1 !== exp_rd(ra1, 1) || rd2 !== exp_rd(ra2, 1) ||
          busy1 !== exp_busy(ra1, 1) || busy2 !== exp_busy(ra2, 1)) begin
        bad++;
        $display("[TB] FAIL rand_bypass n=%0d got %h %h %b %b exp %h %h %b %b", n,
                 rd1, rd2, busy1, busy2, exp_rd(ra1, 1), exp_rd(ra2, 1),
                 exp_busy(ra1, 1), exp_busy(ra2, 1));
      end
      total++;
      if (rd1_nb !== exp_rd(ra1, 0) || rd2_nb !== exp_rd(ra2, 0) ||
          busy1_nb !== exp_busy(ra1, 0) || busy2_nb !== exp_busy(ra2, 0)) begin
        bad++;
        $display("[TB] FAIL rand_nobypass n=%0d got %h %h %b %b exp %h %h %b %b", n,
                 rd1_nb, rd2_nb, busy1_nb, busy2_nb, exp_rd(ra1, 0), exp_rd(ra2, 0),
                 exp_busy(ra1, 0), exp_busy(ra2, 0));
      end
      total++;
      if (pend_cnt !== exp_cnt() || pend_cnt_nb !== exp_cnt()) begin
        bad++;
        $display("[TB] FAIL rand_count n=%0d got=%0d/%0d exp=%0d", n, pend_cnt, pend_cnt_nb, exp_cnt());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    idle();
    ra1 = 0; ra2 = 0;
    @(negedge clk);
    test_reset();
    test_basic_write();
    test_byte_merge();
    test_bypass();
    test_pending();
    test_reg0_and_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter: XLEN, 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: NREG, 32, register count; SHALL be a power of two, at least 2.
REQ-003 Parameter: BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-004 Derived: AW = log2(NREG) is the address width; NB = XLEN/8 is the byte-lane count.
REQ-005 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 Port: rst, input, 1, reset; synchronous, active-high.
REQ-007 Port: ra1, input, AW, read address, port 1.
REQ-008 Port: ra2, input, AW, read address, port 2.
REQ-009 Port: rd1, output, XLEN, read data, port 1.
REQ-010 Port: rd2, output, XLEN, read data, port 2.
REQ-011 Port: busy1, output, 1, register ra1 has a pending write.
REQ-012 Port: busy2, output, 1, register ra2 has a pending write.
REQ-013 Port: we, input, 1, writeback enable.
REQ-014 Port: wa, input, AW, writeback address.
REQ-015 Port: wd, input, XLEN, writeback data.
REQ-016 Port: wbe, input, NB, writeback byte enables; bit k covers wd[8k+7:8k].
REQ-017 Port: iss, input, 1, issue strobe; marks iss_rd pending.
REQ-018 Port: iss_rd, input, AW, destination register of the issuing instruction.
REQ-019 Port: flush, input, 1, clears all pending marks.
REQ-020 Port: pend_cnt, output, AW+1, number of registers currently pending.

Function
REQ-021 Register 0 SHALL always read 0. Writes to register 0 SHALL be discarded. Register 0 SHALL never be pending.
REQ-022 On a rising edge with we=1 and wa!=0, byte lane k of register wa SHALL take wd lane k wherever wbe[k]=1; all other lanes SHALL hold their value.
REQ-023 With we=1 and wbe all zero, register contents SHALL not change; the pending bit SHALL still clear (REQ-027).
REQ-024 Reads SHALL be combinational (zero latency) from the stored array.
REQ-025 With BYPASS=1, if we=1, wa!=0 and ra1==wa, rd1 SHALL return the byte-merged value (wd lanes where wbe=1, stored lanes elsewhere). The same rule SHALL apply to ra2/rd2. Both ports MAY be forwarded in the same cycle.
REQ-026 With BYPASS=0, reads SHALL return the stored value only; new data SHALL be visible the cycle after the write.
REQ-027 Pending bits: iss=1 with iss_rd!=0 SHALL set pending[iss_rd]. we=1 with wa!=0 SHALL clear pending[wa].
REQ-028 If iss and we target the same nonzero register in one cycle, set SHALL win: the register ends pending.
REQ-029 flush=1 SHALL clear every pending bit and SHALL override a same-cycle iss. Register writes in the same cycle SHALL still occur.
REQ-030 busyN SHALL equal pending[raN] from the current state. With BYPASS=1, busyN SHALL read 0 when a same-cycle clearing write to raN is forwarded, unless iss targets raN in that cycle. busyN SHALL be 0 for address 0.
REQ-031 pend_cnt SHALL be a registered population count of the pending bits, consistent with them on every cycle after the edge. Range: 0..NREG-1, so it never wraps.
REQ-032 Setting a bit that is already pending, or clearing one that is not, SHALL leave the count unchanged.

Reset
REQ-033 While rst=1 at a rising edge, all registers SHALL become 0, all pending bits 0, and pend_cnt 0.
REQ-034 rst SHALL dominate iss, we and flush in the same cycle.
REQ-035 A reset asserted mid-sequence SHALL discard outstanding pending state. No write SHALL occur during that cycle.
REQ-036 After reset: rd1, rd2, busy1, busy2 SHALL all be 0 for every address.

Verification
REQ-037 Reset, then write r5=0xDEADBEEF (wbe=1111). Next cycle, ra1=5 SHALL give rd1=0xDEADBEEF, and ra2=0 SHALL give rd2=0.
REQ-038 r5=0xDEADBEEF, then write wd=0x11223344 with wbe=0101 -> r5 SHALL read 0xDE22BE44.
REQ-039 BYPASS=1: same cycle we=1, wa=7, wd=0xA5A5A5A5, ra1=ra2=7 -> rd1=rd2=0xA5A5A5A5 in that cycle, busy1=busy2=0. With BYPASS=0, both SHALL show the old value.
REQ-040 iss r3, then iss r4 -> pend_cnt=2, and ra1=3 gives busy1=1. Then we r3 together with iss r3 in the same cycle -> r3 stays pending, pend_cnt=2.
REQ-041 iss r0 and we r0=0xFFFFFFFF -> pend_cnt=0, r0 reads 0. flush with 5 registers pending -> pend_cnt=0 next cycle.
REQ-042 Pending r2, r9, then rst=1 for one cycle alongside iss r6 and we r9 -> all registers 0, pend_cnt=0, and no pending bits.
